// File: rtl/reset_sequencer.sv
// Power-on / software reset sequencer: holds all reset outputs for a programmable
// time, then releases them one by one in bit order with a fixed gap.
module reset_sequencer #(
  parameter int NUM_OUTPUTS     = 4,
  parameter int CYCLES_IN_RESET = 20,
  parameter int STAGE_DELAY     = 8,
  parameter int SYNC_STAGES     = 3,
  parameter int CNT_W           = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_reset_req,
  input  logic                   hold_reset,
  output logic [NUM_OUTPUTS-1:0] reset_out,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = $clog2(NUM_OUTPUTS + 1);
  localparam logic [CNT_W-1:0]       HOLD_LAST  = CNT_W'(CYCLES_IN_RESET - 1);
  localparam logic [CNT_W-1:0]       STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_OUTPUTS - 1);
  localparam logic [NUM_OUTPUTS-1:0] ALL_ON     = '1;

  if (NUM_OUTPUTS < 1 || NUM_OUTPUTS > 16) begin : g_bad_num_outputs
    $error("reset_sequencer: NUM_OUTPUTS must be in 1..16");
  end
  if (CYCLES_IN_RESET < 1 || CYCLES_IN_RESET >= (2 ** CNT_W)) begin : g_bad_cycles_in_reset
    $error("reset_sequencer: CYCLES_IN_RESET must be >=1 and < 2**CNT_W");
  end
  if (STAGE_DELAY < 1 || STAGE_DELAY >= (2 ** CNT_W)) begin : g_bad_stage_delay
    $error("reset_sequencer: STAGE_DELAY must be >=1 and < 2**CNT_W");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("reset_sequencer: SYNC_STAGES must be >=2");
  end

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_IDLE    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0]   reset_out_d;
  logic                     busy_d;
  logic                     done_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     chain_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // HOLD is entered on the same edge the chain output goes high, so look one stage back.
  assign chain_rise = sync_q[SYNC_STAGES-2] || sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      reset_out <= ALL_ON;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      reset_out <= reset_out_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (state_q != ST_INIT && sw_reset_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (chain_rise) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (hold_reset) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            idx_d = IDX_W'(1);
            if (NUM_OUTPUTS == 1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so the registered copies line up.
  always_comb begin
    reset_out_d = ALL_ON;
    case (state_d)
      ST_INIT:    reset_out_d = ALL_ON;
      ST_HOLD:    reset_out_d = ALL_ON;
      ST_RELEASE: reset_out_d = ALL_ON << idx_d;
      ST_IDLE:    reset_out_d = '0;
      default:    reset_out_d = ALL_ON;
    endcase
    busy_d = |reset_out_d;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal 1-output/1-cycle instance,
// both driven by the same directed and random stimulus and checked against a timeline model.
module tb_reset_sequencer;

  localparam int N0 = 4, CIR0 = 20, SD0 = 8;
  localparam int N1 = 1, CIR1 = 1,  SD1 = 1;
  localparam int SS = 3;
  localparam int W  = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sw_reset_req = 1'b0;
  logic          hold_reset = 1'b0;
  logic [N0-1:0] ro0;
  logic          busy0, done0;
  logic [N1-1:0] ro1;
  logic          busy1, done1;

  reset_sequencer #(.NUM_OUTPUTS(N0), .CYCLES_IN_RESET(CIR0), .STAGE_DELAY(SD0),
                    .SYNC_STAGES(SS), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .sw_reset_req(sw_reset_req), .hold_reset(hold_reset),
    .reset_out(ro0), .busy(busy0), .done(done0)
  );

  reset_sequencer #(.NUM_OUTPUTS(N1), .CYCLES_IN_RESET(CIR1), .STAGE_DELAY(SD1),
                    .SYNC_STAGES(SS), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_reset_req(sw_reset_req), .hold_reset(hold_reset),
    .reset_out(ro1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int errors = 0;
  int checks = 0;

  // Timeline model: each sequence has an anchor edge; bit i is asserted until edge
  // anchor + CIR + i*SD, and done pulses on the edge the last bit drops.
  int edge_k   = 0;
  bit running  = 1'b0;
  int init_cnt = 0;
  int anchor0  = 0;
  int anchor1  = 0;

  function automatic logic [W-1:0] expect_out(int k, int anc, int n, int cir, int sd, bit run);
    logic [15:0] ro;
    logic        dn;
    ro = '0;
    for (int i = 0; i < n; i++) ro[i] = run ? (k < anc + cir + i * sd) : 1'b1;
    dn = run && (k == anc + cir + (n - 1) * sd);
    return {ro, |ro, dn};
  endfunction

  task automatic model_edge();
    edge_k++;
    if (!rst_n) begin
      running  = 1'b0;
      init_cnt = 0;
    end else if (!running) begin
      init_cnt++;
      if (init_cnt == SS) begin
        running = 1'b1;
        anchor0 = edge_k;
        anchor1 = edge_k;
      end
    end else if (sw_reset_req) begin
      anchor0 = edge_k;
      anchor1 = edge_k;
    end else if (hold_reset) begin
      if (edge_k <= anchor0 + CIR0) anchor0 = edge_k;
      if (edge_k <= anchor1 + CIR1) anchor1 = edge_k;
    end
    exp_q0.push_back(expect_out(edge_k, anchor0, N0, CIR0, SD0, running));
    exp_q1.push_back(expect_out(edge_k, anchor1, N1, CIR1, SD1, running));
  endtask

  task automatic step(input bit sw, input bit hold);
    sw_reset_req = sw;
    hold_reset   = hold;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_async(input string name);
    checks++;
    if (ro0 !== 4'hF || busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL %s dut0: got ro=%h busy=%b done=%b, expected ro=f busy=1 done=0",
               name, ro0, busy0, done0);
    end
    checks++;
    if (ro1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL %s dut1: got ro=%h busy=%b done=%b, expected ro=1 busy=1 done=0",
               name, ro1, busy1, done1);
    end
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_async("async_assert");
    step(1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUTs present outputs, compare with the oldest expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    if (exp_q0.size() > 0) begin
      e   = exp_q0.pop_front();
      got = {16'(ro0), busy0, done0};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL dut0_outputs edge %0d: got ro=%h busy=%b done=%b, expected ro=%h busy=%b done=%b",
                 edge_k, got[W-1:2], got[1], got[0], e[W-1:2], e[1], e[0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e   = exp_q1.pop_front();
      got = {16'(ro1), busy1, done1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL dut1_outputs edge %0d: got ro=%h busy=%b done=%b, expected ro=%h busy=%b done=%b",
                 edge_k, got[W-1:2], got[1], got[0], e[W-1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    bit hold_lvl;
    #1 rst_n = 1'b0;
    #1 check_async("por_assert");
    run(5);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Power-on sequence to IDLE
    run(60);

    // hold_reset during HOLD stretches the hold time
    step(1'b1, 1'b0);
    for (int c = 1; c <= 80; c++) step(1'b0, (c >= 10 && c <= 40));

    // Software restart from IDLE
    step(1'b1, 1'b0);
    run(60);

    // Restart mid-release (outputs at 4'b1100)
    step(1'b1, 1'b0);
    run(31);
    step(1'b1, 1'b0);
    run(60);

    // Restart on the done edge suppresses done
    step(1'b1, 1'b0);
    run(43);
    step(1'b1, 1'b0);
    run(60);

    // Async reset mid-release, then a request during INIT that must be ignored
    step(1'b1, 1'b0);
    run(30);
    async_reset_pulse();
    step(1'b1, 1'b0);
    run(60);

    // Random traffic
    hold_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) hold_lvl = ~hold_lvl;
      step($urandom_range(0, 39) == 0, hold_lvl);
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
    end
    run(60);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d/%0d pending, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
